data_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data memory (8-bit data, 5-bit address, combinational read, write on posedge).
- Port 0 is the core load/store unit; port 1 is the debug/loader port.
- Grants one requester at a time with round-robin priority and latches the winning command.
- Drives the memory's W/ADDR/DATA_WR for exactly one cycle, then returns read data with a one-cycle ack pulse.

---
 rtl/data_mem_arbiter_if.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 112 +++++++++++
 tb/tb_data_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// The slave view belongs to the arbiter; the master view belongs to the requesters and memory.
interface data_mem_arbiter_if #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5
);
   logic                 req0;
   logic                 we0;
   logic [ADDR_SIZE-1:0] addr0;
   logic [DATA_SIZE-1:0] wdata0;
   logic                 ack0;
   logic [DATA_SIZE-1:0] rdata0;

   logic                 req1;
   logic                 we1;
   logic [ADDR_SIZE-1:0] addr1;
   logic [DATA_SIZE-1:0] wdata1;
   logic                 ack1;
   logic [DATA_SIZE-1:0] rdata1;

   logic                 mem_w;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [DATA_SIZE-1:0] mem_wdata;
   logic [DATA_SIZE-1:0] mem_rdata;
   logic                 busy;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output ack0, rdata0, ack1, rdata1,
      output mem_w, mem_addr, mem_wdata, busy
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  ack0, rdata0, ack1, rdata1,
      input  mem_w, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters turns on a single-port data memory.
// Each access runs IDLE (grant + latch) -> ACCESS (memory cycle) -> DONE (ack pulse).
module data_mem_arbiter #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5
) (
   input logic                clk,
   input logic                rstn,
   data_mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 sel_q, sel_d;
   logic                 last_gnt_q, last_gnt_d;
   logic                 mem_w_q, mem_w_d;
   logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_SIZE-1:0] mem_wdata_q, mem_wdata_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic [DATA_SIZE-1:0] rdata0_q, rdata0_d;
   logic [DATA_SIZE-1:0] rdata1_q, rdata1_d;
   logic                 pick;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         last_gnt_q  <= 1'b1;
         mem_w_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_gnt_q  <= last_gnt_d;
         mem_w_q     <= mem_w_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_gnt_d  = last_gnt_q;
      mem_w_d     = mem_w_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ack0_d      = ack0_q;
      ack1_d      = ack1_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      pick        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // On a tie the port that did not win last time goes first.
               if (bus.req0 && bus.req1) pick = ~last_gnt_q;
               else                      pick = bus.req1;
               sel_d       = pick;
               last_gnt_d  = pick;
               mem_w_d     = pick ? bus.we1    : bus.we0;
               mem_addr_d  = pick ? bus.addr1  : bus.addr0;
               mem_wdata_d = pick ? bus.wdata1 : bus.wdata0;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            mem_w_d = 1'b0;
            if (sel_q) begin
               ack1_d = 1'b1;
               if (!mem_w_q) rdata1_d = bus.mem_rdata;
            end else begin
               ack0_d = 1'b1;
               if (!mem_w_q) rdata0_d = bus.mem_rdata;
            end
            state_d = DONE;
         end
         DONE: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_w     = mem_w_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 32x8 memory (reset contents mem[i]=i).
module tb_data_mem_arbiter;
   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       mem_init = 1'b0;
   logic [7:0] mem [32];
   int         n_checks = 0;
   int         n_fail = 0;

   data_mem_arbiter_if #(.DATA_SIZE(8), .ADDR_SIZE(5)) bus ();

   data_mem_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(5)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
      end else if (bus.mem_w) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rstn = 1'b0;
      mem_init = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      mem_init = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 rstn = 1'b0;
      mem_init = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL reset_mem_w: got %b, expected 0", bus.mem_w); end
      n_checks++; if (bus.mem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 00", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, expected 00", bus.mem_wdata); end
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack0: got %b, expected 0", bus.ack0); end
      n_checks++; if (bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack1: got %b, expected 0", bus.ack1); end
      n_checks++; if (bus.rdata0 !== 8'h00) begin n_fail++; $display("FAIL reset_rdata0: got %h, expected 00", bus.rdata0); end
      n_checks++; if (bus.rdata1 !== 8'h00) begin n_fail++; $display("FAIL reset_rdata1: got %h, expected 00", bus.rdata1); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
      rstn = 1'b1;
      mem_init = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b, expected 0", bus.busy); end
   endtask

   task automatic test_write_p0();
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd5; bus.wdata0 = 8'hA5;
      @(negedge clk);
      n_checks++; if (bus.mem_w !== 1'b1) begin n_fail++; $display("FAIL wr_access_mem_w: got %b, expected 1", bus.mem_w); end
      n_checks++; if (bus.mem_addr !== 5'd5) begin n_fail++; $display("FAIL wr_access_addr: got %h, expected 05", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_access_wdata: got %h, expected a5", bus.mem_wdata); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wr_access_busy: got %b, expected 1", bus.busy); end
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_access_ack0: got %b, expected 0", bus.ack0); end
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b1) begin n_fail++; $display("FAIL wr_done_ack0: got %b, expected 1", bus.ack0); end
      n_checks++; if (bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL wr_done_ack1: got %b, expected 0", bus.ack1); end
      n_checks++; if (bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL wr_done_mem_w: got %b, expected 0", bus.mem_w); end
      n_checks++; if (mem[5] !== 8'hA5) begin n_fail++; $display("FAIL wr_mem_content: got %h, expected a5", mem[5]); end
      bus.req0 = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_idle_ack0: got %b, expected 0", bus.ack0); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy: got %b, expected 0", bus.busy); end
   endtask

   task automatic test_read_p1();
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5; bus.wdata1 = 8'h00;
      @(negedge clk);
      n_checks++; if (bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL rd1_access_mem_w: got %b, expected 0", bus.mem_w); end
      n_checks++; if (bus.mem_addr !== 5'd5) begin n_fail++; $display("FAIL rd1_access_addr: got %h, expected 05", bus.mem_addr); end
      @(negedge clk);
      n_checks++; if (bus.ack1 !== 1'b1) begin n_fail++; $display("FAIL rd1_ack1: got %b, expected 1", bus.ack1); end
      n_checks++; if (bus.rdata1 !== 8'hA5) begin n_fail++; $display("FAIL rd1_rdata1: got %h, expected a5", bus.rdata1); end
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL rd1_ack0: got %b, expected 0", bus.ack0); end
      n_checks++; if (bus.rdata0 !== 8'h00) begin n_fail++; $display("FAIL rd1_rdata0_kept: got %h, expected 00", bus.rdata0); end
      bus.req1 = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL rd1_idle_ack1: got %b, expected 0", bus.ack1); end
      n_checks++; if (bus.rdata1 !== 8'hA5) begin n_fail++; $display("FAIL rd1_rdata1_held: got %h, expected a5", bus.rdata1); end
   endtask

   task automatic test_read_after_reset();
      apply_reset();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd3;
      @(negedge clk);
      n_checks++; if (bus.mem_addr !== 5'd3) begin n_fail++; $display("FAIL rd0_access_addr: got %h, expected 03", bus.mem_addr); end
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b1) begin n_fail++; $display("FAIL rd0_ack0: got %b, expected 1", bus.ack0); end
      n_checks++; if (bus.rdata0 !== 8'h03) begin n_fail++; $display("FAIL rd0_rdata0: got %h, expected 03", bus.rdata0); end
      n_checks++; if (bus.rdata1 !== 8'h00) begin n_fail++; $display("FAIL rd0_rdata1_kept: got %h, expected 00", bus.rdata1); end
      bus.req0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic exp0, exp1;
      apply_reset();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd2;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd9;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp0 = (k == 2) || (k == 8);
         exp1 = (k == 5) || (k == 11);
         n_checks++; if (bus.ack0 !== exp0) begin n_fail++; $display("FAIL rr_ack0 cycle %0d: got %b, expected %b", k, bus.ack0, exp0); end
         n_checks++; if (bus.ack1 !== exp1) begin n_fail++; $display("FAIL rr_ack1 cycle %0d: got %b, expected %b", k, bus.ack1, exp1); end
         if (k == 2) begin
            n_checks++; if (bus.rdata0 !== 8'h02) begin n_fail++; $display("FAIL rr_rdata0: got %h, expected 02", bus.rdata0); end
         end
         if (k == 5) begin
            n_checks++; if (bus.rdata1 !== 8'h09) begin n_fail++; $display("FAIL rr_rdata1: got %h, expected 09", bus.rdata1); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_access();
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd7; bus.wdata0 = 8'hFF;
      @(negedge clk);
      n_checks++; if (bus.mem_w !== 1'b1) begin n_fail++; $display("FAIL mid_pre_mem_w: got %b, expected 1", bus.mem_w); end
      rstn = 1'b0;
      #1;
      n_checks++; if (bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL mid_mem_w: got %b, expected 0", bus.mem_w); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b, expected 0", bus.busy); end
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL mid_ack0: got %b, expected 0", bus.ack0); end
      n_checks++; if (bus.mem_addr !== 5'd0) begin n_fail++; $display("FAIL mid_mem_addr: got %h, expected 00", bus.mem_addr); end
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL mid_hold_ack0: got %b, expected 0", bus.ack0); end
      rstn = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd1;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd2;
      @(negedge clk);
      n_checks++; if (bus.mem_addr !== 5'd1) begin n_fail++; $display("FAIL mid_next_grant_addr: got %h, expected 01", bus.mem_addr); end
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b1) begin n_fail++; $display("FAIL mid_next_ack0: got %b, expected 1", bus.ack0); end
      n_checks++; if (bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL mid_next_ack1: got %b, expected 0", bus.ack1); end
      n_checks++; if (bus.rdata0 !== 8'h01) begin n_fail++; $display("FAIL mid_next_rdata0: got %h, expected 01", bus.rdata0); end
      idle_inputs();
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_end_busy: got %b, expected 0", bus.busy); end
   endtask

   task automatic test_drop_req();
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd12; bus.wdata0 = 8'h3C;
      @(negedge clk);
      n_checks++; if (bus.mem_w !== 1'b1) begin n_fail++; $display("FAIL drop_mem_w: got %b, expected 1", bus.mem_w); end
      bus.req0 = 1'b0; bus.addr0 = 5'h1F; bus.wdata0 = 8'h00;
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b1) begin n_fail++; $display("FAIL drop_ack0: got %b, expected 1", bus.ack0); end
      n_checks++; if (bus.mem_addr !== 5'd12) begin n_fail++; $display("FAIL drop_addr_latched: got %h, expected 0c", bus.mem_addr); end
      n_checks++; if (mem[12] !== 8'h3C) begin n_fail++; $display("FAIL drop_mem_content: got %h, expected 3c", mem[12]); end
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL drop_ack0_once: got %b, expected 0", bus.ack0); end
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd12;
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL drop_no_extra_ack0: got %b, expected 0", bus.ack0); end
      @(negedge clk);
      n_checks++; if (bus.ack1 !== 1'b1) begin n_fail++; $display("FAIL drop_rd_ack1: got %b, expected 1", bus.ack1); end
      n_checks++; if (bus.rdata1 !== 8'h3C) begin n_fail++; $display("FAIL drop_rd_rdata1: got %h, expected 3c", bus.rdata1); end
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_write_p0();
      test_read_p1();
      test_read_after_reset();
      test_round_robin();
      test_reset_mid_access();
      test_drop_req();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
